// File: rtl/dma_write.sv
// rtl/dma_write.sv - AXI4 master write DMA: stream words to memory in 4 KB-safe INCR bursts
module dma_write #(
    parameter int C_M_AXI_ID_WIDTH     = 1,
    parameter int C_M_AXI_ADDR_WIDTH   = 32,
    parameter int C_M_AXI_DATA_WIDTH   = 32,
    parameter int C_M_AXI_AWUSER_WIDTH = 1,
    parameter int BITS_TRANS           = 18
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     i_base_addr,
    input  logic [31:0]                       i_byte_len,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_error,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     i_data,
    input  logic                              i_valid,
    output logic                              o_ready,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWLOCK,
    output logic [3:0]                        M_AXI_AWCACHE,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic [3:0]                        M_AXI_AWQOS,
    output logic [C_M_AXI_AWUSER_WIDTH-1:0]   M_AXI_AWUSER,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_BID,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [BITS_TRANS-1:0] remaining_q, remaining_d;
    logic [8:0]            beats_q, beats_d;
    logic [7:0]            awlen_q, awlen_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic [BITS_TRANS-1:0] start_words;
    logic [12:0]           page_bytes;
    logic [10:0]           page_words;
    logic [8:0]            beats_calc;
    logic [8:0]            beats_calc_m1;
    logic [BITS_TRANS-1:0] remaining_after;
    logic                  w_beat;

    assign start_words = i_byte_len[BITS_TRANS+1:2];
    assign w_beat      = (state_q == S_DATA) && i_valid && M_AXI_WREADY;

    // Burst sizing: limited by 256 beats, the words left, and the room before the next 4 KB page.
    always_comb begin
        page_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
        page_words = page_bytes[12:2];
        beats_calc = 9'd256;
        if ({{(32-BITS_TRANS){1'b0}}, remaining_q} < 32'd256) begin
            beats_calc = remaining_q[8:0];
        end
        if (page_words < {2'b00, beats_calc}) begin
            beats_calc = page_words[8:0];
        end
        beats_calc_m1   = beats_calc - 9'd1;
        remaining_after = remaining_q - {{(BITS_TRANS-9){1'b0}}, beats_q};
    end

    // Transfer FSM: next state and next values of all registered control fields.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        awlen_d     = awlen_q;
        beat_cnt_d  = beat_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d      = {i_base_addr[AW-1:2], 2'b00};
                    remaining_d = start_words;
                    error_d     = 1'b0;
                    if (start_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                beats_d    = beats_calc;
                awlen_d    = beats_calc_m1[7:0];
                beat_cnt_d = 8'd0;
                state_d    = S_ADDR;
            end
            S_ADDR: begin
                if (M_AXI_AWREADY) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == awlen_q) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        error_d = 1'b1;
                    end
                    addr_d      = addr_q + {{(AW-11){1'b0}}, beats_q, 2'b00};
                    remaining_d = remaining_after;
                    if (remaining_after == '0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and control registers; reset abandons any burst in flight.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            beats_q     <= '0;
            awlen_q     <= '0;
            beat_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            beats_q     <= beats_d;
            awlen_q     <= awlen_d;
            beat_cnt_q  <= beat_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_error = error_q;

    // The stream is only drained while a burst's data phase is open, so W never precedes its AW.
    assign o_ready       = (state_q == S_DATA) && M_AXI_WREADY;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = awlen_q;
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0000;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'hF;
    assign M_AXI_AWUSER  = '0;
    assign M_AXI_AWVALID = (state_q == S_ADDR);

    assign M_AXI_WDATA   = (state_q == S_DATA) ? i_data : '0;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = (state_q == S_DATA) && (beat_cnt_q == awlen_q);
    assign M_AXI_WVALID  = (state_q == S_DATA) && i_valid;

    assign M_AXI_BREADY  = (state_q == S_RESP);

    logic unused_ok;
    assign unused_ok = &{1'b0, M_AXI_BID, i_byte_len[31:BITS_TRANS+2], i_byte_len[1:0],
                         i_base_addr[1:0], page_bytes[1:0]};

endmodule

// File: tb/tb_dma_write.sv
// tb/tb_dma_write.sv - directed self-checking bench for dma_write
module tb_dma_write;

    logic        clk;
    logic        ARESETN;
    logic        i_start;
    logic [31:0] i_base_addr;
    logic [31:0] i_byte_len;
    logic        o_busy, o_done, o_error;
    logic [31:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [0:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;
    logic [0:0]  awuser;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [0:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    dma_write dut (
        .ACLK(clk), .ARESETN(ARESETN), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_byte_len(i_byte_len), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
        .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWUSER(awuser),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // slave / stream configuration and observation logs
    int          aw_delay = 0;
    int          stall_at = -1;
    int          err_burst = -1;
    bit          gaps = 1'b0;
    logic [31:0] data_base = 32'h0;
    int          word_idx = 0;
    int          b_count = 0;
    int          w_total = 0;
    int          done_cnt = 0;
    logic        done_err = 1'b0;
    int          first_aw_cyc = -1;
    int          wlast_err = 0;
    int          viol = 0;
    int          aw_unstable = 0;
    int          start_cyc = 0;
    logic [31:0] aw_addr_log[$];
    logic [7:0]  aw_len_log[$];
    logic [31:0] w_data_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // AXI slave model, stream source and protocol monitor
    initial begin : slave
        bit          aw_hs, w_hs, b_hs, s_hs;
        bit          aw_open, aw_hold, bpend;
        int          aw_wait, stall_left, beat;
        logic [7:0]  cur_len, held_len;
        logic [31:0] held_addr;
        aw_open = 0; aw_hold = 0; bpend = 0; aw_wait = 0; stall_left = 0; beat = 0;
        cur_len = 0; held_len = 0; held_addr = 0;
        awready = 0; wready = 1; bvalid = 0; bresp = 0; bid = 0; i_valid = 0; i_data = 0;
        forever begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            s_hs  = i_valid && o_ready;
            if (awvalid && first_aw_cyc < 0) first_aw_cyc = cyc;
            if (o_done) begin done_cnt++; done_err = o_error; end
            if (aw_hold && awvalid && (awaddr != held_addr || awlen != held_len)) aw_unstable++;
            aw_hold = awvalid && !awready;
            held_addr = awaddr; held_len = awlen;
            if (o_ready && !aw_open) viol++;
            if (s_hs != w_hs) viol++;
            if (w_hs && !aw_open) viol++;
            if (aw_hs) begin
                aw_addr_log.push_back(awaddr);
                aw_len_log.push_back(awlen);
                aw_open = 1; cur_len = awlen; beat = 0;
            end
            if (w_hs) begin
                w_data_log.push_back(wdata);
                if (wlast != (beat == int'(cur_len))) wlast_err++;
                beat++;
                w_total++;
                if (w_total == stall_at) stall_left = 3;
                if (wlast) begin aw_open = 0; bpend = 1; end
            end
            if (s_hs) word_idx++;
            if (b_hs) b_count++;
            @(posedge clk);
            #1;
            if (!ARESETN) begin
                aw_open = 0; aw_hold = 0; bpend = 0; aw_wait = 0; stall_left = 0;
                bvalid = 0; awready = 0;
            end
            if (aw_hs) begin
                aw_wait = 0; awready = 0;
            end else if (awvalid) begin
                awready = (aw_wait >= aw_delay);
                aw_wait++;
            end else begin
                awready = 0;
            end
            wready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (b_hs) bvalid = 0;
            if (bpend) begin
                bvalid = 1;
                bresp = (b_count == err_burst) ? 2'b10 : 2'b00;
                bpend = 0;
            end
            i_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_data  = data_base + word_idx;
        end
    end

    task automatic clear_logs(input logic [31:0] dbase);
        aw_addr_log.delete(); aw_len_log.delete(); w_data_log.delete();
        data_base = dbase; word_idx = 0; b_count = 0; w_total = 0; done_cnt = 0;
        done_err = 0; first_aw_cyc = -1; wlast_err = 0; viol = 0; aw_unstable = 0;
    endtask

    task automatic start(input logic [31:0] base, input logic [31:0] len);
        @(posedge clk); #1;
        i_base_addr = base; i_byte_len = len; i_start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin @(negedge clk); n++; end
        chk({tag, "_done_seen"}, done_cnt != 0, 1);
        repeat (4) @(negedge clk);
        chk({tag, "_done_once"}, done_cnt, 1);
    endtask

    task automatic chk_data(input string tag, input int n);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            if (k >= w_data_log.size() || w_data_log[k] !== data_base + k) bad++;
        end
        chk({tag, "_wcount"}, w_data_log.size(), n);
        chk({tag, "_order"}, bad, 0);
        chk({tag, "_wlast"}, wlast_err, 0);
        chk({tag, "_proto"}, viol, 0);
    endtask

    function automatic logic [31:0] aw_a(input int i);
        return (i < aw_addr_log.size()) ? aw_addr_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [7:0] aw_l(input int i);
        return (i < aw_len_log.size()) ? aw_len_log[i] : 8'hXX;
    endfunction

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        ARESETN = 1'b0; i_start = 1'b0; i_base_addr = 0; i_byte_len = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outs", {o_busy, o_done, o_error, awvalid, wvalid, bready, o_ready, awaddr}, 0);
        chk("static_fields", {awid, awsize, awburst, awlock, awcache, awprot, awqos, awuser, wstrb},
            {1'b0, 3'b010, 2'b01, 1'b0, 4'h0, 3'h0, 4'hF, 1'b0, 4'hF});
        ARESETN = 1'b1;
        repeat (2) @(posedge clk);

        // single 4-beat burst
        clear_logs(32'hA0);
        start(32'h1000, 16);
        @(negedge clk);
        chk("t1_busy", o_busy, 1);
        wait_done("t1", 200);
        chk("t1_latency", first_aw_cyc - start_cyc, 2);
        chk("t1_awcount", aw_addr_log.size(), 1);
        chk("t1_awaddr", aw_a(0), 32'h1000);
        chk("t1_awlen", aw_l(0), 3);
        chk_data("t1", 4);
        chk("t1_error", done_err, 0);
        chk("t1_idle", o_busy, 0);

        // 4 KB in four 256-beat bursts
        clear_logs(32'h1000_0000);
        start(32'h0, 32'h1000);
        wait_done("t2", 5000);
        chk("t2_awcount", aw_addr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_awaddr%0d", i), aw_a(i), 32'h400 * i);
            chk($sformatf("t2_awlen%0d", i), aw_l(i), 255);
        end
        chk_data("t2", 1024);

        // 4 KB page split
        clear_logs(32'h2000_0000);
        start(32'h0FF0, 32);
        wait_done("t3", 300);
        chk("t3_awcount", aw_addr_log.size(), 2);
        chk("t3_awaddr0", aw_a(0), 32'hFF0);
        chk("t3_awlen0", aw_l(0), 3);
        chk("t3_awaddr1", aw_a(1), 32'h1000);
        chk("t3_awlen1", aw_l(1), 3);
        chk_data("t3", 8);

        // backpressure: stream gaps, WREADY stall, slow AWREADY
        clear_logs(32'h3000_0000);
        gaps = 1'b1; aw_delay = 5; stall_at = 6;
        start(32'h2000, 64);
        wait_done("t4", 1000);
        chk("t4_awstable", aw_unstable, 0);
        chk("t4_awlen", aw_l(0), 15);
        chk_data("t4", 16);
        gaps = 1'b0; aw_delay = 0; stall_at = -1;

        // error response on first burst does not abort
        clear_logs(32'h4000_0000);
        err_burst = 0;
        start(32'h3000, 2048);
        wait_done("t5", 3000);
        err_burst = -1;
        chk("t5_awcount", aw_addr_log.size(), 2);
        chk("t5_awaddr1", aw_a(1), 32'h3400);
        chk("t5_done_error", done_err, 1);
        chk("t5_sticky", o_error, 1);
        chk_data("t5", 512);

        // zero length: done at cycle 1, no AW, error cleared
        clear_logs(32'h0);
        start(32'h6000, 0);
        @(negedge clk);
        chk("t6_done_c1", {o_done, o_busy}, 2'b10);
        chk("t6_err_clear", o_error, 0);
        repeat (6) @(negedge clk);
        chk("t6_no_aw", first_aw_cyc, -1);
        chk("t6_done_once", done_cnt, 1);

        // reset mid-burst, then a normal transfer
        clear_logs(32'h5000_0000);
        start(32'h4000, 64);
        begin
            int n;
            n = 0;
            while (w_total < 3 && n < 200) begin @(negedge clk); n++; end
            chk("t7_beats_started", w_total >= 3, 1);
        end
        @(posedge clk); #2;
        ARESETN = 1'b0;
        #1;
        chk("t7_rst_outs", {awvalid, wvalid, bready, o_ready, o_busy, o_done}, 0);
        repeat (2) @(posedge clk);
        #2;
        ARESETN = 1'b1;
        repeat (2) @(posedge clk);
        clear_logs(32'hC0);
        start(32'h5000, 16);
        wait_done("t7", 200);
        chk("t7_awaddr", aw_a(0), 32'h5000);
        chk("t7_awlen", aw_l(0), 3);
        chk_data("t7", 4);
        chk("t7_error", done_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_write.md
Name: dma_write

Overview:
AXI4 master write DMA engine. It is the write-side counterpart of the accelerator's read DMA. It accepts a word stream from the systolic-array result path and writes it to external memory starting at a programmed base address. Transfers use INCR bursts of up to 256 beats, and no burst crosses a 4 KB boundary. The block sits between the engine's output buffer and the AXI interconnect, and is driven by the same start/busy/done control as the read DMA.

Parameters:
C_M_AXI_ID_WIDTH, 1, AWID/BID width
C_M_AXI_ADDR_WIDTH, 32, address width
C_M_AXI_DATA_WIDTH, 32, data width; beat = 4 bytes
C_M_AXI_AWUSER_WIDTH, 1, AWUSER width (driven 0)
BITS_TRANS, 18, width of the word counters; max transfer 2^BITS_TRANS-1 words

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
i_start  in  1  one-cycle start pulse; ignored while o_busy=1
i_base_addr  in  32  byte address; bits[1:0] ignored
i_byte_len  in  32  byte count; words = i_byte_len[BITS_TRANS+1:2]
o_busy  out  1  transfer in progress
o_done  out  1  one-cycle completion pulse
o_error  out  1  sticky: any BRESP!=OKAY since last start
i_data  in  DATA  stream word
i_valid  in  1  stream valid
o_ready  out  1  stream ready
M_AXI_AWID/AWADDR/AWLEN[8]/AWSIZE[3]/AWBURST[2]/AWLOCK/AWCACHE[4]/AWPROT[3]/AWQOS[4]/AWUSER/AWVALID  out  AW channel
M_AXI_AWREADY  in  1
M_AXI_WDATA/WSTRB[DATA/8]/WLAST/WVALID  out  W channel
M_AXI_WREADY  in  1
M_AXI_BID/BRESP[2]  in  B channel
M_AXI_BVALID  in  1
M_AXI_BREADY  out  1

Behaviour:
- Reset values: all outputs 0, including o_busy, o_done, o_error, AWVALID, WVALID, BREADY and o_ready. The FSM resets to IDLE.
- Static AXI fields: AWID=0, AWSIZE=3'b010, AWBURST=2'b01, AWLOCK=0, AWCACHE=0, AWPROT=0, AWQOS=4'hF, AWUSER=0, WSTRB all ones.
- FSM states: IDLE, CALC, ADDR, DATA, RESP.
- IDLE: on i_start, register addr={i_base_addr[31:2],2'b00}, register remaining=word count, clear o_error, set o_busy.
  - If the word count is 0, go to IDLE and pulse o_done the next cycle with no AXI traffic.
  - Otherwise go to CALC.
- CALC (1 cycle): beats = min(256, remaining, (4096-addr[11:0])>>2). Register AWLEN=beats-1 and clear beat_cnt. Go to ADDR.
- ADDR: AWVALID=1 with AWADDR=addr. AWVALID and all AW fields stay stable until AWREADY. On the handshake go to DATA.
- DATA:
  - WVALID = i_valid; WDATA = i_data (combinational); o_ready = M_AXI_WREADY.
  - A beat transfers when i_valid & WREADY; each beat increments beat_cnt.
  - WLAST = (beat_cnt==AWLEN).
  - On the WLAST beat go to RESP.
  - W data is never issued before the AW handshake of its burst.
- RESP: BREADY=1. On BVALID:
  - If BRESP!=2'b00, set o_error (sticky).
  - addr += beats*4; remaining -= beats.
  - If remaining==0: go to IDLE, pulse o_done with o_busy falling in the same cycle.
  - Otherwise go to CALC. An error does not abort; the remaining bursts are still issued.
- o_ready=0 in every state except DATA, so stream words are never consumed outside a burst.
- Latency: i_start at cycle 0 gives AWVALID at cycle 2, given AWREADY=1 and no backpressure.
- Outstanding transactions: one burst at a time; the next AW is not issued until the previous B is received.
- Address arithmetic is modulo 2^32.
- i_start while busy is ignored and the registered parameters are unchanged.
- Reset asserted mid-transfer: immediate return to IDLE, all valids drop, counters clear. No completion of the interrupted burst is attempted.

Test Plan:
- i_base_addr=0x1000, i_byte_len=16, stream 0xA0..0xA3 -> one AW (AWADDR=0x1000, AWLEN=3), 4 W beats with WLAST on the 4th, BRESP=OKAY -> o_done pulse, o_error=0.
- i_base_addr=0x0, i_byte_len=0x1000 -> 4 bursts at 0x0/0x400/0x800/0xC00, each AWLEN=255, data in order, exactly one o_done.
- i_base_addr=0x0FF0, i_byte_len=32 -> burst 1 AWADDR=0xFF0 AWLEN=3, burst 2 AWADDR=0x1000 AWLEN=3.
- Random i_valid gaps, WREADY low 3 cycles mid-burst, AWREADY delayed 5 cycles -> AW fields stable while waiting, no beats lost or duplicated, o_ready=0 outside DATA.
- 2-burst transfer (2048 bytes), first BRESP=2'b10 -> second burst still issued; o_done pulses with o_error=1; o_error clears on the next i_start.
- i_byte_len=0 -> o_done at cycle 1, no AWVALID. ARESETN low mid-burst -> all valids 0, o_busy 0; a new start afterwards completes normally.
